// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter and its downstream encoder checker.
// Holds the state encoding, a constant clog2 and a one-hot to index helper.
package rr_arb_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  typedef enum logic {
    StIdle  = IDLE,
    StGrant = GRANT
  } arb_state_e;

  // Widest one-hot vector the index helper accepts; callers zero-extend.
  localparam int unsigned OhMaxW = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Returns the position of the highest set bit; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [OhMaxW-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < OhMaxW; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Circular priority pick: first set request at or after ptr, wrapping N-1 to 0.
// Built as a masked (>= ptr) and an unmasked lowest-index encoder.
module rr_priority_select
  import rr_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  logic [N-1:0]     mask;
  logic [N-1:0]     masked;
  logic [IDX_W-1:0] pick_masked;
  logic [IDX_W-1:0] pick_unmasked;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (IDX_W'(i) >= ptr);
    end
    masked = req & mask;
  end

  // Scan downward so the lowest set index is the one left standing.
  always_comb begin
    pick_masked   = '0;
    pick_unmasked = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (masked[i]) pick_masked = IDX_W'(i);
      if (req[i])    pick_unmasked = IDX_W'(i);
    end
  end

  assign pick = (|masked) ? pick_masked : pick_unmasked;
  assign any  = |req;

endmodule

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with registered one-hot grant, binary index, busy and a
// forced-release timeout. Every grant is followed by at least one idle cycle.
module rr_arbiter_onehot
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDX_W   = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             rel,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned HOLD_W = clog2(MAX_HOLD + 1);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("N must be a power of two and at least 2");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("MAX_HOLD must be at least 2");
  end

  arb_state_e        state_q;
  logic [N-1:0]      gnt_q;
  logic [IDX_W-1:0]  gnt_idx_q;
  logic              busy_q;
  logic              timeout_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [HOLD_W-1:0] hold_cnt_q;

  logic [IDX_W-1:0] pick;
  logic             any;
  logic             owner_req;
  logic             hold_max;
  logic             release_now;
  logic             forced;

  rr_priority_select #(
    .N(N)
  ) u_select (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  assign owner_req   = req[gnt_idx_q];
  assign hold_max    = (hold_cnt_q == HOLD_W'(MAX_HOLD));
  assign release_now = rel | ~owner_req | hold_max;
  // Only a pure hold-limit release counts as a timeout.
  assign forced      = hold_max & ~rel & owner_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          timeout_q <= 1'b0;
          if (any) begin
            state_q    <= StGrant;
            gnt_q      <= N'(1) << pick;
            gnt_idx_q  <= pick;
            busy_q     <= 1'b1;
            hold_cnt_q <= HOLD_W'(1);
          end
        end
        StGrant: begin
          if (release_now) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= forced;
            ptr_q      <= gnt_idx_q + IDX_W'(1);
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// Scoreboard bench for rr_arbiter_onehot: directed stimulus queues the expected
// grant records; a negedge monitor closes each observed grant and compares.
module tb_rr_arbiter_onehot;

  logic       clk = 1'b0;
  logic       rst;
  logic       rel;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    int         len;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;

  bit         chk_en   = 1'b0;
  bit         in_grant = 1'b0;
  logic [3:0] cur_gnt;
  logic [1:0] cur_idx;
  int         cur_len;
  logic [1:0] ref_idx;

  rr_arbiter_onehot #(
    .N        (4),
    .MAX_HOLD (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] i, input int len, input logic to);
    exp_t e;
    e.gnt = g;
    e.idx = i;
    e.len = len;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  // From an idle cycle with req set: grant appears, held h cycles, released by rel.
  task automatic grant_release(input logic [3:0] g, input logic [1:0] i, input int h);
    push(g, i, h, 1'b0);
    tick(1);
    tick(h - 1);
    rel = 1'b1;
    tick(1);
    rel = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ref_idx = 2'd0;
      for (int b = 0; b < 4; b++) if (gnt[b]) ref_idx = 2'(b);
      check("onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      check("idx_consistent", {30'd0, gnt_idx}, {30'd0, ref_idx});
      check("busy_matches_gnt", {31'd0, busy}, {31'd0, (gnt != 4'd0)});
      check("timeout_only_idle", {31'd0, timeout & busy}, 32'd0);
      if (busy === 1'b1) begin
        if (!in_grant) begin
          in_grant = 1'b1;
          cur_gnt  = gnt;
          cur_idx  = gnt_idx;
          cur_len  = 1;
        end else begin
          cur_len++;
          check("gnt_stable", {28'd0, gnt}, {28'd0, cur_gnt});
        end
      end else if (in_grant) begin
        in_grant = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got gnt=%b with no expected record", cur_gnt);
        end else begin
          exp_e = exp_q.pop_front();
          check("grant_vec", {28'd0, cur_gnt}, {28'd0, exp_e.gnt});
          check("grant_idx", {30'd0, cur_idx}, {30'd0, exp_e.idx});
          check("grant_len", cur_len, exp_e.len);
          check("timeout_flag", {31'd0, timeout}, {31'd0, exp_e.to});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    rel = 1'b0;
    tick(2);
    check("reset_gnt", {28'd0, gnt}, 32'd0);
    check("reset_idx", {30'd0, gnt_idx}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    chk_en = 1'b1;

    // Fairness from ptr=0, ends with ptr=1
    rst = 1'b0;
    grant_release(4'b0001, 2'd0, 1);
    grant_release(4'b0010, 2'd1, 1);
    grant_release(4'b0100, 2'd2, 1);
    grant_release(4'b1000, 2'd3, 1);
    grant_release(4'b0001, 2'd0, 1);

    // Single requester, rel in third grant cycle; ptr becomes 3
    req = 4'b0100;
    grant_release(4'b0100, 2'd2, 3);

    // Wrap from ptr=3 skips to idx 0; ptr becomes 1
    req = 4'b0011;
    grant_release(4'b0001, 2'd0, 2);

    // Hold limit reached with no rel: timeout pulse, then same requester again
    req = 4'b0010;
    push(4'b0010, 2'd1, 8, 1'b1);
    tick(9);
    grant_release(4'b0010, 2'd1, 8);

    // Owner drops request on its third cycle
    push(4'b0010, 2'd1, 3, 1'b0);
    tick(3);
    req = 4'b0000;
    tick(1);

    // Reset mid-grant of idx 2 (ptr=2); afterwards search restarts at 0
    req = 4'b0100;
    push(4'b0100, 2'd2, 2, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("midgrant_reset_gnt", {28'd0, gnt}, 32'd0);
    rst = 1'b0;
    req = 4'b1111;
    grant_release(4'b0001, 2'd0, 1);

    req = 4'b0000;
    tick(3);
    check("queue_drained", exp_q.size(), 32'd0);
    check("no_open_grant", {31'd0, in_grant}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
